// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Op codes, latencies, flag positions, rounding modes and FSM
//               state type shared by the FPU issue sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [5:0] OP_ADD      = 6'd0;
    localparam logic [5:0] OP_MUL      = 6'd1;
    localparam logic [5:0] OP_DIV      = 6'd2;
    localparam logic [5:0] OP_SQRT     = 6'd3;
    localparam logic [5:0] OP_CVT_S_W  = 6'd4;
    localparam logic [5:0] OP_CVT_S_WU = 6'd5;
    localparam logic [5:0] OP_CVT_W_S  = 6'd6;
    localparam logic [5:0] OP_CVT_WU_S = 6'd7;
    localparam logic [5:0] OP_MAX      = OP_CVT_WU_S;

    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 3;
    localparam int CVT_LAT = 1;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Only meaningful for legal ops; illegal codes never reach BUSY.
    function automatic logic [CNT_W-1:0] op_latency(input logic [5:0] op,
                                                    input int        div_lat,
                                                    input int        sqrt_lat);
        case (op)
            OP_ADD:  return CNT_W'(ADD_LAT);
            OP_MUL:  return CNT_W'(MUL_LAT);
            OP_DIV:  return CNT_W'(div_lat);
            OP_SQRT: return CNT_W'(sqrt_lat);
            default: return CNT_W'(CVT_LAT);
        endcase
    endfunction

    function automatic logic rm_legal(input logic [2:0] rm);
        return rm <= RM_RMM;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_seq_if
// Description : Core-side issue/result handshake of the FPU issue sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_seq_if #(
    parameter int FLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [5:0]      in_op;
    logic [2:0]      in_rm;
    logic [FLEN-1:0] in_rs1;
    logic [FLEN-1:0] in_rs2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [FLEN-1:0] out_result;
    logic            out_illegal;

    modport master (
        output in_valid, in_op, in_rm, in_rs1, in_rs2, kill, out_ready,
        input  in_ready, out_valid, out_result, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_rm, in_rs1, in_rs2, kill, out_ready,
        output in_ready, out_valid, out_result, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/fcsr_reg.sv
`default_nettype none
// ============================================================================
// Module      : fcsr_reg
// Description : fcsr storage; a CSR write overrides a same-cycle flag OR.
// Revision    : 1.0 - initial release
// ============================================================================
module fcsr_reg
    import fpu_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        csr_we_i,
    input  wire logic [7:0]  csr_wdata_i,
    input  wire logic        flag_we_i,
    input  wire logic [4:0]  flags_i,
    output logic      [31:0] fcsr_o
);

    logic [7:0] fcsr_q;
    logic [7:0] fcsr_d;

    always_comb begin
        fcsr_d = fcsr_q;
        if (csr_we_i) begin
            fcsr_d = csr_wdata_i;
        end else if (flag_we_i) begin
            fcsr_d[4:0] = fcsr_q[4:0] | flags_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fcsr_q <= '0;
        end else begin
            fcsr_q <= fcsr_d;
        end
    end

    assign fcsr_o = {24'b0, fcsr_q};

endmodule
`default_nettype wire

// File: rtl/fpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpu_seq
// Description : Single-op issue sequencer in front of a fixed-latency FPU.
//               Define FPU_SEQ_SKID_EN to accept a new op in the retire cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int FLEN     = 32,
    parameter int DIV_LAT  = 12,
    parameter int SQRT_LAT = 14
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    fpu_seq_if.slave             core,
    output logic      [5:0]      fpu_op,
    output logic      [FLEN-1:0] fpu_rs1,
    output logic      [FLEN-1:0] fpu_rs2,
    output logic      [31:0]     fpu_fcsr,
    input  wire logic [FLEN-1:0] fpu_result,
    input  wire logic [4:0]      fpu_flags,
    input  wire logic            csr_we,
    input  wire logic [7:0]      csr_wdata,
    output logic      [31:0]     fcsr
);

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]      op_q;
    logic [FLEN-1:0] rs1_q;
    logic [FLEN-1:0] rs2_q;
    logic [7:0]      fcsr_lat_q;
    logic [FLEN-1:0] result_q;
    logic            illegal_q;

    logic [2:0]      w_rm_res;
    logic            w_illegal;
    logic            w_accept;
    logic            w_capture;

    assign w_rm_res  = (core.in_rm == RM_DYN) ? fcsr[7:5] : core.in_rm;
    assign w_illegal = (core.in_op > OP_MAX) || !rm_legal(w_rm_res);
    assign w_accept  = core.in_valid && core.in_ready;
    // kill wins over a capture in the final BUSY cycle.
    assign w_capture = (state_q == BUSY) && !core.kill && (cnt_q == CNT_W'(1));

`ifdef FPU_SEQ_SKID_EN
    assign core.in_ready = (state_q == IDLE) || ((state_q == DONE) && core.out_ready);
`else
    assign core.in_ready = (state_q == IDLE);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            fcsr_lat_q <= '0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
        end else if (w_accept) begin
            op_q       <= core.in_op;
            rs1_q      <= core.in_rs1;
            rs2_q      <= core.in_rs2;
            fcsr_lat_q <= {w_rm_res, fcsr[4:0]};
            if (w_illegal) begin
                state_q   <= DONE;
                illegal_q <= 1'b1;
                result_q  <= '0;
            end else begin
                state_q   <= BUSY;
                illegal_q <= 1'b0;
                cnt_q     <= op_latency(core.in_op, DIV_LAT, SQRT_LAT);
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (core.kill) begin
                        state_q <= IDLE;
                    end else if (w_capture) begin
                        result_q <= fpu_result;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (core.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core.out_valid   = (state_q == DONE);
    assign core.out_result  = result_q;
    assign core.out_illegal = illegal_q;

    assign fpu_op   = op_q;
    assign fpu_rs1  = rs1_q;
    assign fpu_rs2  = rs2_q;
    assign fpu_fcsr = {24'b0, fcsr_lat_q};

    fcsr_reg u_fcsr (
        .clk         (clk),
        .resetn      (resetn),
        .csr_we_i    (csr_we),
        .csr_wdata_i (csr_wdata),
        .flag_we_i   (w_capture),
        .flags_i     (fpu_flags),
        .fcsr_o      (fcsr)
    );

endmodule
`default_nettype wire
